// File: rtl/arena_pkg.sv
// Shared encodings for the arena filler: fill modes, FSM states and default LFSR taps.
package arena_pkg;

  typedef enum logic [1:0] {
    ModeRandom  = 2'd0,
    ModeClear   = 2'd1,
    ModeFill    = 2'd2,
    ModeChecker = 2'd3
  } arena_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StWrite = 2'd3
  } arena_state_e;

  // Wide enough for the largest legal LFSR; users truncate to their width.
  localparam logic [63:0] DefaultLfsrTaps = 64'h0000_0000_8020_0003;

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR: shifts left, folding the tap mask in whenever the bit shifted out was 1.
module lfsr_galois
  import arena_pkg::*;
#(
  parameter int unsigned           width = 32,
  parameter logic [width-1:0] taps  = width'(DefaultLfsrTaps)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] value,
  input  logic             advance,
  output logic             msb
);

  logic [width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = value;
    end else if (advance) begin
      state_d = state_q[width-1] ? ((state_q << 1) ^ taps) : (state_q << 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= width'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign msb = state_q[width-1];

endmodule

// File: rtl/arena_filler.sv
// Fills an arena row by row with a pattern, handing each row to the arena through a
// write/ready handshake.
module arena_filler
  import arena_pkg::*;
#(
  parameter int unsigned           ARENA_WIDTH  = 10,
  parameter int unsigned           ARENA_HEIGHT = 10,
  parameter int unsigned           LFSR_WIDTH   = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = LFSR_WIDTH'(DefaultLfsrTaps)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [LFSR_WIDTH-1:0]  seed,
  output logic                   ready,
  output logic                   done,
  output logic [7:0]             arena_row_select,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write,
  input  logic                   arena_write_ready
);

  localparam logic [7:0] LastCol = 8'(ARENA_WIDTH - 1);
  localparam logic [7:0] LastRow = 8'(ARENA_HEIGHT - 1);

  arena_state_e           state_q;
  arena_mode_e            mode_q;
  logic [7:0]             row_q, col_q;
  logic [ARENA_WIDTH-1:0] bits_q;
  logic                   done_q;

  logic                  lfsr_load, lfsr_advance, lfsr_msb, shift_bit;
  logic [LFSR_WIDTH-1:0] lfsr_seed;

  assign lfsr_load    = (state_q == StIdle) && start && !abort;
  // An all-zero seed would lock the LFSR up, so substitute 1.
  assign lfsr_seed    = (seed == '0) ? LFSR_WIDTH'(1) : seed;
  assign lfsr_advance = (state_q == StShift) && (mode_q == ModeRandom);

  lfsr_galois #(
    .width (LFSR_WIDTH),
    .taps  (LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .value   (lfsr_seed),
    .advance (lfsr_advance),
    .msb     (lfsr_msb)
  );

  always_comb begin
    shift_bit = 1'b0;
    unique case (mode_q)
      ModeRandom:  shift_bit = lfsr_msb;
      ModeClear:   shift_bit = 1'b0;
      ModeFill:    shift_bit = 1'b1;
      ModeChecker: shift_bit = ~(row_q[0] ^ col_q[0]);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= ModeRandom;
      row_q   <= '0;
      col_q   <= '0;
      bits_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            mode_q  <= arena_mode_e'(mode);
            state_q <= StLoad;
          end
        end
        StLoad: begin
          row_q   <= '0;
          col_q   <= '0;
          bits_q  <= '0;
          state_q <= abort ? StIdle : StShift;
        end
        StShift: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            // First bit shifted in travels up to the MSB, which is column 0.
            bits_q <= {bits_q[ARENA_WIDTH-2:0], shift_bit};
            col_q  <= col_q + 8'd1;
            if (col_q == LastCol) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (arena_write_ready) begin
            if (row_q == LastRow) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              row_q   <= row_q + 8'd1;
              col_q   <= '0;
              state_q <= StShift;
            end
          end
        end
      endcase
    end
  end

  assign ready               = (state_q == StIdle);
  assign done                = done_q;
  assign arena_row_select    = row_q;
  assign arena_columns_new   = bits_q;
  assign arena_columns_write = (state_q == StWrite);

endmodule

// File: tb/tb_arena_filler.sv
// Directed bench for arena_filler on an 8x4 arena: fill patterns, timing, stalls, abort, reset.
module tb_arena_filler;
  import arena_pkg::*;

  localparam int unsigned     W    = 8;
  localparam int unsigned     H    = 4;
  localparam int unsigned     LW   = 32;
  localparam logic [LW-1:0]   TAPS = 32'h8020_0003;
  localparam int              DONE_CYC = H * (W + 1) + 2;  // 38

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [LW-1:0] seed = '0;
  logic          ready, done, wr;
  logic          wr_rdy = 1'b1;
  logic [7:0]    row_sel;
  logic [W-1:0]  cols;

  int n_checks = 0;
  int n_errors = 0;

  int           wr_count, done_cyc, hold_cyc, nw, nd;
  bit           hold_stable;
  logic [7:0]   wr_row  [8];
  logic [W-1:0] wr_data [8];
  int           wr_cyc  [8];
  logic [W-1:0] exp_rows [H];
  logic [LW-1:0] st;

  always #5 clk = ~clk;

  arena_filler #(
    .ARENA_WIDTH  (W),
    .ARENA_HEIGHT (H),
    .LFSR_WIDTH   (LW),
    .LFSR_TAPS    (TAPS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .mode                (mode),
    .seed                (seed),
    .ready               (ready),
    .done                (done),
    .arena_row_select    (row_sel),
    .arena_columns_new   (cols),
    .arena_columns_write (wr),
    .arena_write_ready   (wr_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] s);
    return s[LW-1] ? ((s << 1) ^ TAPS) : (s << 1);
  endfunction

  // Leaves the bench one cycle after the start cycle (cycle 1).
  task automatic launch(input logic [1:0] m, input logic [LW-1:0] s);
    mode  = m;
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed  = '0;
  endtask

  task automatic collect(input int stall_row, input int stall_len, input bit poke);
    int stalled = 0;
    logic [W-1:0] held = '0;
    wr_count = 0; done_cyc = -1; hold_cyc = 0; hold_stable = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      start = poke && (c == 3);
      if (poke && c == 3) mode = ModeFill;
      wr_rdy = 1'b1;
      if (wr && int'(row_sel) == stall_row) begin
        if (hold_cyc == 0) held = cols;
        else if (cols !== held) hold_stable = 1'b0;
        hold_cyc++;
        if (stalled < stall_len) begin
          wr_rdy = 1'b0;
          stalled++;
        end
      end
      if (wr && wr_rdy) begin
        if (wr_count < 8) begin
          wr_row[wr_count]  = row_sel;
          wr_data[wr_count] = cols;
          wr_cyc[wr_count]  = c;
        end
        wr_count++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start  = 1'b0;
    wr_rdy = 1'b1;
  endtask

  task automatic check_fill(input string tag, input int exp_done);
    check({tag, " writes"}, 64'(wr_count), 64'(H));
    for (int r = 0; r < int'(H); r++) begin
      check($sformatf("%s row%0d sel", tag, r), 64'(wr_row[r]), 64'(r));
      check($sformatf("%s row%0d data", tag, r), 64'(wr_data[r]), 64'(exp_rows[r]));
    end
    check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
    tick();
    check({tag, " done pulse ends"}, 64'(done), 64'(0));
    check({tag, " ready after"}, 64'(ready), 64'(1));
  endtask

  task automatic watch(input int n, output int writes, output int dones);
    writes = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      if (wr) writes++;
      if (done) dones++;
      tick();
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst ready", 64'(ready), 64'(1));
    check("rst done", 64'(done), 64'(0));
    check("rst write", 64'(wr), 64'(0));
    check("rst row_sel", 64'(row_sel), 64'(0));
    check("rst cols", 64'(cols), 64'(0));
    reset = 1'b0;
    tick();

    // CLEAR, with a start poke mid-fill that must be ignored.
    launch(ModeClear, 32'h0);
    collect(-1, 0, 1'b1);
    for (int r = 0; r < int'(H); r++) exp_rows[r] = 8'h00;
    check("clear first write cycle", 64'(wr_cyc[0]), 64'(W + 2));
    check("clear second write cycle", 64'(wr_cyc[1]), 64'(2 * W + 3));
    check_fill("clear", DONE_CYC);

    launch(ModeChecker, 32'h0);
    collect(-1, 0, 1'b0);
    exp_rows[0] = 8'hAA; exp_rows[1] = 8'h55; exp_rows[2] = 8'hAA; exp_rows[3] = 8'h55;
    check_fill("checker", DONE_CYC);

    // Seed 0 runs as seed 1: the single 1 reaches the MSB after 31 shifts.
    launch(ModeRandom, 32'h0);
    collect(-1, 0, 1'b0);
    exp_rows[0] = 8'h00; exp_rows[1] = 8'h00; exp_rows[2] = 8'h00; exp_rows[3] = 8'h01;
    check_fill("random seed0", DONE_CYC);

    launch(ModeRandom, 32'h8000_0000);
    collect(-1, 0, 1'b0);
    st = 32'h8000_0000;
    for (int r = 0; r < int'(H); r++) begin
      exp_rows[r] = '0;
      for (int c = 0; c < int'(W); c++) begin
        exp_rows[r] = {exp_rows[r][W-2:0], st[LW-1]};
        st = lfsr_next(st);
      end
    end
    check("random row0 hand", 64'(wr_data[0]), 64'(8'hFF));
    check_fill("random seed8", DONE_CYC);

    // FILL with row 1 stalled for 5 cycles.
    launch(ModeFill, 32'h0);
    collect(1, 5, 1'b0);
    for (int r = 0; r < int'(H); r++) exp_rows[r] = 8'hFF;
    check("stall hold cycles", 64'(hold_cyc), 64'(6));
    check("stall data stable", 64'(hold_stable), 64'(1));
    check("stall accept cycle", 64'(wr_cyc[1]), 64'(2 * W + 3 + 5));
    check_fill("stall", DONE_CYC + 5);

    // abort alone, and start together with abort, are ignored in IDLE.
    abort = 1'b1;
    tick();
    check("idle abort ready", 64'(ready), 64'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("start+abort ignored", 64'(ready), 64'(1));

    // abort during SHIFT of row 1.
    launch(ModeFill, 32'h0);
    for (int i = 0; i < 11; i++) tick();
    check("shift row1 sel", 64'(row_sel), 64'(1));
    check("shift row1 no write", 64'(wr), 64'(0));
    check("shift row1 busy", 64'(ready), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort shift ready", 64'(ready), 64'(1));
    check("abort shift done", 64'(done), 64'(0));
    watch(30, nw, nd);
    check("abort shift writes", 64'(nw), 64'(0));
    check("abort shift dones", 64'(nd), 64'(0));
    launch(ModeClear, 32'h0);
    collect(-1, 0, 1'b0);
    for (int r = 0; r < int'(H); r++) exp_rows[r] = 8'h00;
    check_fill("after abort", DONE_CYC);

    // abort together with an accepted write.
    launch(ModeFill, 32'h0);
    for (int i = 0; i < int'(W) + 1; i++) tick();
    check("abort write pending", 64'(wr), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort write ready", 64'(ready), 64'(1));
    check("abort write done", 64'(done), 64'(0));
    watch(20, nw, nd);
    check("abort write writes", 64'(nw), 64'(0));
    check("abort write dones", 64'(nd), 64'(0));

    // reset while a write is pending.
    launch(ModeFill, 32'h0);
    for (int i = 0; i < int'(W) + 1; i++) tick();
    check("reset write pending", 64'(wr), 64'(1));
    reset = 1'b1;
    #1;
    check("async rst ready", 64'(ready), 64'(1));
    check("async rst write", 64'(wr), 64'(0));
    check("async rst done", 64'(done), 64'(0));
    check("async rst row_sel", 64'(row_sel), 64'(0));
    check("async rst cols", 64'(cols), 64'(0));
    tick();
    reset = 1'b0;
    watch(30, nw, nd);
    check("post rst writes", 64'(nw), 64'(0));
    check("post rst dones", 64'(nd), 64'(0));
    check("post rst ready", 64'(ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
